// File: rtl/ysyx_22040759_id_stage_pkg.sv
// Shared decode-stage definitions: opcodes, format encodings, bus widths and
// the field offsets of the decode-to-execute bus.
// Imported by ysyx_22040759_id_stage and ysyx_22040759_imm_gen.
package ysyx_22040759_id_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int FS_TO_DS_BUS_WD = 96;
  localparam int DS_TO_ES_BUS_WD = 299;
  localparam int FWD_BUS_WD      = 72;

  // RV64I major opcodes
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Forwarding bus from EX/MEM/WB: {valid, we, is_load, rd, data}
  typedef struct packed {
    logic        valid;
    logic        we;
    logic        is_load;
    logic [4:0]  rd;
    logic [63:0] data;
  } fwd_t;

  // ds_to_es_bus field offsets (LSB positions)
  localparam int PC_LSB     = 0;
  localparam int INST_LSB   = 64;
  localparam int IMM_LSB    = 96;
  localparam int SRC1_LSB   = 160;
  localparam int SRC2_LSB   = 224;
  localparam int RD_LSB     = 288;
  localparam int RF_WE_BIT  = 293;
  localparam int FMT_LSB    = 294;
  localparam int MEM_RD_BIT = 297;
  localparam int MEM_WR_BIT = 298;

endpackage

// File: rtl/ysyx_22040759_imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of inst to 64 bits.
// Combinational, zero latency; no handshake.
// Ports: inst (32-bit instruction), fmt (decoded format) -> imm (64-bit).
module ysyx_22040759_imm_gen
  import ysyx_22040759_id_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  fmt_e        fmt,
  output logic [63:0] imm
);

  // Opcode bits are never part of an immediate.
  logic unused_opc;
  assign unused_opc = ^inst[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{52{inst[31]}}, inst[31:20]};
      FMT_S: imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      FMT_J: imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_id_stage.sv
// Decode stage: registers the fetch bus, decodes RV64I, resolves operands via
// EX/MEM/WB bypass, drives the execute bus. Latency: 1 cycle fetch->execute.
// Backpressure: holds on es_allowin=0 or load-use stall (pcwrite=1); br_taken flushes.
// Ports: fs_to_ds_* (fetch handshake), rf_* (register file read), *_fwd_bus
// (bypass sources), ds_to_es_* (execute bus), pcwrite (fetch freeze).
module ysyx_22040759_id_stage
  import ysyx_22040759_id_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_allowin,
  input  logic                       es_allowin,
  input  logic                       br_taken,
  output logic                       pcwrite,
  output logic [4:0]                 rf_raddr1,
  output logic [4:0]                 rf_raddr2,
  input  logic [63:0]                rf_rdata1,
  input  logic [63:0]                rf_rdata2,
  input  logic [FWD_BUS_WD-1:0]      es_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ms_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ws_fwd_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus
);

  logic                       ds_valid;
  logic                       ds_ready_go;
  logic [FS_TO_DS_BUS_WD-1:0] fs_bus_r;

  logic [31:0] inst;
  logic [63:0] pc;
  logic [4:0]  rd;
  fmt_e        fmt;
  logic        rs1_used, rs2_used;
  logic        rf_we, mem_rd, mem_wr;
  logic [63:0] imm;

  fwd_t es_fwd, ms_fwd, ws_fwd;
  logic [4:0]  src_addr [2];
  logic [63:0] src_rf   [2];
  logic [63:0] src      [2];
  logic        src_load [2];

  assign inst = fs_bus_r[95:64];
  assign pc   = fs_bus_r[63:0];
  assign rd   = inst[11:7];

  assign es_fwd = es_fwd_bus;
  assign ms_fwd = ms_fwd_bus;
  assign ws_fwd = ws_fwd_bus;

  // Only EX can still be producing load data; MEM/WB data is always final.
  logic unused_fwd;
  assign unused_fwd = ms_fwd.is_load ^ ws_fwd.is_load;

  // Pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_valid <= 1'b0;
      fs_bus_r <= {NOP_INST, 64'h0};
    end else begin
      if (br_taken)
        ds_valid <= 1'b0;
      else if (ds_allowin)
        ds_valid <= fs_to_ds_valid;
      if (ds_allowin && fs_to_ds_valid && !br_taken)
        fs_bus_r <= fs_to_ds_bus;
    end
  end

  // Format decode
  always_comb begin
    fmt = FMT_ILL;
    case (inst[6:0])
      OPC_OP, OPC_OP_32:                          fmt = FMT_R;
      OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD,
      OPC_JALR, OPC_SYSTEM:                       fmt = FMT_I;
      OPC_STORE:                                  fmt = FMT_S;
      OPC_BRANCH:                                 fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
      OPC_JAL:                                    fmt = FMT_J;
      default:                                    fmt = FMT_ILL;
    endcase
  end

  assign rs1_used = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rf_we    = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                    && (rd != 5'd0);
  assign mem_rd   = (inst[6:0] == OPC_LOAD);
  assign mem_wr   = (inst[6:0] == OPC_STORE);

  ysyx_22040759_imm_gen u_imm_gen (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  assign rf_raddr1   = inst[19:15];
  assign rf_raddr2   = inst[24:20];
  assign src_addr[0] = rf_raddr1;
  assign src_addr[1] = rf_raddr2;
  assign src_rf[0]   = rf_rdata1;
  assign src_rf[1]   = rf_rdata2;

  // Bypass mux per source: youngest producer wins. An EX hit on a load marks
  // the operand as not yet available.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src[i]      = src_rf[i];
      src_load[i] = 1'b0;
      if (src_addr[i] == 5'd0) begin
        src[i] = '0;
      end else if (es_fwd.valid && es_fwd.we && es_fwd.rd == src_addr[i]) begin
        src[i]      = es_fwd.data;
        src_load[i] = es_fwd.is_load;
      end else if (ms_fwd.valid && ms_fwd.we && ms_fwd.rd == src_addr[i]) begin
        src[i] = ms_fwd.data;
      end else if (ws_fwd.valid && ws_fwd.we && ws_fwd.rd == src_addr[i]) begin
        src[i] = ws_fwd.data;
      end
    end
  end

  assign ds_ready_go    = !(ds_valid && ((rs1_used && src_load[0]) || (rs2_used && src_load[1])));
  assign pcwrite        = ds_valid && !ds_ready_go;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !br_taken;

  // Empty stage presents a NOP so execute never sees stale fields.
  always_comb begin
    ds_to_es_bus = '0;
    if (ds_valid) begin
      ds_to_es_bus[MEM_WR_BIT]         = mem_wr;
      ds_to_es_bus[MEM_RD_BIT]         = mem_rd;
      ds_to_es_bus[FMT_LSB +: 3]       = fmt;
      ds_to_es_bus[RF_WE_BIT]          = rf_we;
      ds_to_es_bus[RD_LSB +: 5]        = rd;
      ds_to_es_bus[SRC2_LSB +: 64]     = src[1];
      ds_to_es_bus[SRC1_LSB +: 64]     = src[0];
      ds_to_es_bus[IMM_LSB +: 64]      = imm;
      ds_to_es_bus[INST_LSB +: 32]     = inst;
      ds_to_es_bus[PC_LSB +: 64]       = pc;
    end else begin
      ds_to_es_bus[INST_LSB +: 32]     = NOP_INST;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_id_stage.sv
// Directed bench for the decode stage: reset, decode/immediates, bypass
// priority, load-use stall, backpressure hold and branch flush.
module tb_ysyx_22040759_id_stage;

  logic         clk;
  logic         rst;
  logic         fs_to_ds_valid;
  logic [95:0]  fs_to_ds_bus;
  logic         ds_allowin;
  logic         es_allowin;
  logic         br_taken;
  logic         pcwrite;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [63:0]  rf_rdata1, rf_rdata2;
  logic [71:0]  es_fwd_bus, ms_fwd_bus, ws_fwd_bus;
  logic         ds_to_es_valid;
  logic [298:0] ds_to_es_bus;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22040759_id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .es_allowin     (es_allowin),
    .br_taken       (br_taken),
    .pcwrite        (pcwrite),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus),
    .ws_fwd_bus     (ws_fwd_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus)
  );

  // Execute-bus fields, sliced by hand from the documented layout
  logic        o_mem_wr, o_mem_rd, o_rf_we;
  logic [2:0]  o_fmt;
  logic [4:0]  o_rd;
  logic [63:0] o_src2, o_src1, o_imm, o_pc;
  logic [31:0] o_inst;
  assign o_mem_wr = ds_to_es_bus[298];
  assign o_mem_rd = ds_to_es_bus[297];
  assign o_fmt    = ds_to_es_bus[296:294];
  assign o_rf_we  = ds_to_es_bus[293];
  assign o_rd     = ds_to_es_bus[292:288];
  assign o_src2   = ds_to_es_bus[287:224];
  assign o_src1   = ds_to_es_bus[223:160];
  assign o_imm    = ds_to_es_bus[159:96];
  assign o_inst   = ds_to_es_bus[95:64];
  assign o_pc     = ds_to_es_bus[63:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then drop valid.
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {inst, pc};
    @(posedge clk);
    #1;
    fs_to_ds_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
    es_allowin = 1'b1; br_taken = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    es_fwd_bus = '0; ms_fwd_bus = '0; ws_fwd_bus = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", ds_to_es_valid, 0);
    chk("rst_allowin", ds_allowin, 1);
    chk("rst_pcwrite", pcwrite, 0);
    rst = 1'b0;
    #1;
    chk("empty_inst", o_inst, 64'h13);
    chk("empty_pc", o_pc, 0);
    chk("empty_hi_zero", |ds_to_es_bus[298:96], 0);
    tick();
    chk("idle_vld", ds_to_es_valid, 0);

    // ADDI x5,x1,-1
    rf_rdata1 = 64'd7;
    issue(32'hFFF08293, 64'h8000_0000);
    chk("addi_vld", ds_to_es_valid, 1);
    chk("addi_fmt", o_fmt, 1);
    chk("addi_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_src1", o_src1, 7);
    chk("addi_rd", o_rd, 5);
    chk("addi_rf_we", o_rf_we, 1);
    chk("addi_raddr1", rf_raddr1, 1);
    chk("addi_pc", o_pc, 64'h8000_0000);

    // Load-use: ADD x4,x3,x2 behind a load to x3 in EX
    es_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd3, 64'h0};
    rf_rdata1 = 64'h99; rf_rdata2 = 64'h22;
    issue(32'h0021_8233, 64'h8000_0004);
    chk("lu_pcwrite", pcwrite, 1);
    chk("lu_allowin", ds_allowin, 0);
    chk("lu_vld", ds_to_es_valid, 0);
    tick();
    chk("lu_pcwrite_hold", pcwrite, 1);
    chk("lu_inst_hold", o_inst, 32'h0021_8233);
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd3, 64'h55};  // is_load ignored in MEM
    #1;
    chk("lu_rel_vld", ds_to_es_valid, 1);
    chk("lu_rel_pcwrite", pcwrite, 0);
    chk("lu_rel_src1_mem", o_src1, 64'h55);
    chk("lu_rel_src2_rf", o_src2, 64'h22);
    chk("add_fmt", o_fmt, 0);
    chk("add_rd", o_rd, 4);
    ms_fwd_bus = '0;
    #1;
    chk("src1_rf", o_src1, 64'h99);
    ws_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd3, 64'h77};
    #1;
    chk("src1_wb", o_src1, 64'h77);
    ws_fwd_bus = {1'b1, 1'b0, 1'b0, 5'd3, 64'h77};
    #1;
    chk("src1_wb_no_we", o_src1, 64'h99);
    ws_fwd_bus = '0;
    tick();
    chk("drain_vld", ds_to_es_valid, 0);
    chk("drain_allowin", ds_allowin, 1);

    // Bypass priority: ADDI x7,x6,1 with x6 in EX, MEM and WB
    es_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd6, 64'hA};
    ms_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd6, 64'hB};
    ws_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd6, 64'hC};
    issue(32'h0013_0393, 64'h8000_0008);
    chk("prio_src1_ex", o_src1, 64'hA);
    chk("prio_imm", o_imm, 1);
    // rs1 = x0: always zero, and a load "to x0" in EX never stalls
    es_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd0, 64'hD};
    ms_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd0, 64'hB};
    ws_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd0, 64'hC};
    rf_rdata1 = 64'h1234;
    issue(32'h0010_0393, 64'h8000_000C);
    chk("x0_src1", o_src1, 0);
    chk("x0_pcwrite", pcwrite, 0);
    chk("x0_vld", ds_to_es_valid, 1);
    es_fwd_bus = '0; ms_fwd_bus = '0; ws_fwd_bus = '0;

    // Backpressure hold, then flush
    issue(32'hFFF0_8293, 64'h10);
    es_allowin = 1'b0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {32'h0010_0393, 64'hDEAD};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_vld", ds_to_es_valid, 1);
      chk("hold_allowin", ds_allowin, 0);
      chk("hold_pc", o_pc, 64'h10);
      chk("hold_inst", o_inst, 32'hFFF0_8293);
    end
    br_taken = 1'b1;
    #1;
    chk("flush_same_cycle_vld", ds_to_es_valid, 0);
    tick();
    br_taken = 1'b0;
    fs_to_ds_valid = 1'b0;
    #1;
    chk("flush_vld", ds_to_es_valid, 0);
    chk("flush_allowin", ds_allowin, 1);
    chk("flush_empty_inst", o_inst, 64'h13);
    es_allowin = 1'b1;

    // Flush during a load-use stall
    es_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd1, 64'h0};
    issue(32'hFFF0_8293, 64'h20);
    chk("stall_pcwrite", pcwrite, 1);
    br_taken = 1'b1;
    #1;
    chk("stall_br_pcwrite", pcwrite, 1);
    chk("stall_br_vld", ds_to_es_valid, 0);
    tick();
    br_taken = 1'b0;
    es_fwd_bus = '0;
    #1;
    chk("stall_br_after_vld", ds_to_es_valid, 0);
    chk("stall_br_after_pcwrite", pcwrite, 0);

    // Format / immediate decode
    issue(32'hFE00_0EE3, 64'h30);  // BEQ x0,x0,-4
    chk("beq_fmt", o_fmt, 3);
    chk("beq_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rf_we", o_rf_we, 0);
    issue(32'hFE20_BC23, 64'h34);  // SD x2,-8(x1)
    chk("sd_fmt", o_fmt, 2);
    chk("sd_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sd_mem_wr", o_mem_wr, 1);
    chk("sd_rf_we", o_rf_we, 0);
    chk("sd_src2", o_src2, 64'h22);
    issue(32'h0101_3483, 64'h38);  // LD x9,16(x2)
    chk("ld_fmt", o_fmt, 1);
    chk("ld_imm", o_imm, 16);
    chk("ld_mem_rd", o_mem_rd, 1);
    chk("ld_mem_wr", o_mem_wr, 0);
    issue(32'h1234_50B7, 64'h3C);  // LUI x1,0x12345
    chk("lui_fmt", o_fmt, 4);
    chk("lui_imm", o_imm, 64'h1234_5000);
    chk("lui_rf_we", o_rf_we, 1);
    issue(32'h0080_00EF, 64'h40);  // JAL x1,8
    chk("jal_fmt", o_fmt, 5);
    chk("jal_imm", o_imm, 8);
    issue(32'h0000_0013, 64'h44);  // ADDI x0,x0,0
    chk("nop_rf_we_rd0", o_rf_we, 0);
    issue(32'h0000_0FFF, 64'h48);  // opcode 7F, rd=31
    chk("ill_fmt", o_fmt, 7);
    chk("ill_rf_we", o_rf_we, 0);
    chk("ill_imm", o_imm, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_id_stage.md
Name: ysyx_22040759_id_stage

Overview:
Decode stage directly downstream of the fetch stage. It consumes the 96-bit fetch bus {inst[95:64], pc[63:0]} under a valid/allowin handshake and holds it in a single pipeline register. It decodes RV64I formats, generates immediates, reads the register file, and resolves operands through EX/MEM/WB bypasses. It detects load-use hazards, asserts pcwrite to freeze fetch, and drives the execute-stage bus.

Parameters:
NOP_INST, 32'h00000013, instruction field driven on ds_to_es_bus when stage is empty
DS_TO_ES_BUS_WD, 299, width of ds_to_es_bus (fixed; package constant)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
fs_to_ds_valid  in  1  fetch bus valid
fs_to_ds_bus  in  96  {inst 32, pc 64}
ds_allowin  out  1  stage can accept fetch bus this cycle
es_allowin  in  1  execute stage can accept
br_taken  in  1  redirect from execute; flush
pcwrite  out  1  1 = freeze fetch PC (load-use stall)
rf_raddr1  out  5  RF read addr = inst[19:15]
rf_raddr2  out  5  RF read addr = inst[24:20]
rf_rdata1  in  64  RF read data 1, combinational
rf_rdata2  in  64  RF read data 2, combinational
es_fwd_bus  in  72  {valid, we, is_load, rd 5, data 64}
ms_fwd_bus  in  72  same layout; is_load ignored
ws_fwd_bus  in  72  same layout; is_load ignored
ds_to_es_valid  out  1  execute bus valid
ds_to_es_bus  out  299  {mem_wr, mem_rd, fmt 3, rf_we, rd 5, src2 64, src1 64, imm 64, inst 32, pc 64}, MSB first

Behaviour:
- Reset (async, rst=1): ds_valid=0; stored bus = {NOP_INST, 64'h0}. Outputs during reset: ds_to_es_valid=0, pcwrite=0, ds_allowin=1.
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - On a clock edge with ds_allowin=1: ds_valid <= fs_to_ds_valid; bus captured only if fs_to_ds_valid=1.
  - ds_to_es_valid = ds_valid && ds_ready_go && !br_taken.
- Flush: br_taken=1 at an edge forces ds_valid <= 0, overriding any capture that cycle. Same cycle, ds_to_es_valid=0.
- Empty stage: ds_to_es_bus = all zeros, except inst=NOP_INST and pc=0.
- Decode by opcode inst[6:0]:
  - Formats (fmt): R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
  - OP/OP-32 (0110011/0111011) -> R.
  - OP-IMM/OP-IMM-32/LOAD/JALR/SYSTEM (0010011/0011011/0000011/1100111/1110011) -> I.
  - STORE 0100011 -> S. BRANCH 1100011 -> B. LUI/AUIPC (0110111/0010111) -> U. JAL 1101111 -> J. Any other opcode -> ILL.
- Immediates, sign-extended to 64 bits:
  - I: inst[31:20]. S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}. J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R/ILL: imm=0.
- Control fields:
  - rf_we = 1 for R/I/U/J, 0 for S/B/ILL; forced 0 when rd==0.
  - mem_rd = LOAD; mem_wr = STORE.
- Operand resolution, per source, address a:
  - a==0 -> 0.
  - Otherwise priority: EX hit, then MEM hit, then WB hit, then rf_rdata. Hit = valid && we && rd==a.
  - EX hit with is_load=1 -> operand unavailable; this is a load-use hazard.
- Source usage: rs1 used for R/I/S/B; rs2 used for R/S/B. Unused sources never cause stalls.
- Stall: ds_ready_go = !(ds_valid && load-use hazard on a used source). pcwrite = ds_valid && !ds_ready_go. While stalled: register holds, ds_allowin=0, ds_to_es_valid=0.
- Simultaneous br_taken with a stall: the flush wins. ds_valid cleared; pcwrite still follows the combinational formula that cycle.
- Latency: 1 cycle from fetch capture to execute bus valid with no hazard.

Decomposition:
- Shared package/define file holds: opcode constants, fmt encodings, DS_TO_ES_BUS_WD, FWD_BUS_WD=72, and bus field offsets.
- One sub-module, ysyx_22040759_imm_gen: combinational; inputs inst and fmt, output imm[63:0].
- Bypass muxes stay inline, one instance per source.

Test Plan:
- Reset released, fs_to_ds_valid=0 -> ds_to_es_valid=0, ds_allowin=1, pcwrite=0, bus inst=32'h13, pc=0.
- Fetch ADDI x5,x1,-1 (32'hFFF08293) at pc 0x80000000, rf_rdata1=7, es_allowin=1:
  - -> next cycle ds_to_es_valid=1, fmt=1, imm=64'hFFFF_FFFF_FFFF_FFFF, src1=7, rd=5, rf_we=1.
- es_fwd = {1,1,1,rd=3,x}, decode ADD x4,x3,x2:
  - -> pcwrite=1, ds_allowin=0, ds_to_es_valid=0.
  - Drop es is_load next cycle -> issues with src1 taken from MEM/WB/RF.
- rs1=6 hit in EX (data 0xA, non-load), MEM (0xB) and WB (0xC) simultaneously -> src1=0xA. Same with rs1=0 -> src1=0.
- Valid instruction held with es_allowin=0 for 3 cycles -> bus stable, ds_allowin=0. br_taken pulse -> ds_valid=0 next cycle.
- Decode BEQ 32'hFE000EE3 -> fmt=3, imm=64'hFFFF_FFFF_FFFF_FFFC, rf_we=0. Opcode 7'h7F -> fmt=7, rf_we=0, imm=0.
